alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter DW, default 32, which sets the operand and result width.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 The block SHALL have ports req0_valid / req1_valid  input  1 each  request present.
REQ-005 The block SHALL have ports req0_ready / req1_ready  output  1 each  request accepted this cycle.
REQ-006 The block SHALL have ports req0_op / req1_op  input  3 each  opcode.
REQ-007 The block SHALL have ports req0_a, req0_b, req1_a, req1_b  input  DW each  operands.
REQ-008 The block SHALL have port resp_valid  output  1  result available.
REQ-009 The block SHALL have port resp_ready  input  1  consumer takes the result.
REQ-010 The block SHALL have port resp_id  output  1  requester index of the result.
REQ-011 The block SHALL have port resp_c  output  DW  result.
REQ-012 The block SHALL have ports resp_zero, resp_overflow, resp_carry, resp_illegal  output  1 each  result flags.

Function
REQ-013 The FSM SHALL have states IDLE, EXEC and RESP.
REQ-014 In IDLE the FSM SHALL assert reqN_ready combinationally for exactly the granted valid requester; every ready SHALL be 0 in EXEC and RESP.
REQ-015 On reqN_valid & reqN_ready the block SHALL latch op, a, b and id, then move to EXEC.
REQ-016 EXEC SHALL last one cycle, register the result and flags from the latched operands, then move to RESP.
REQ-017 In RESP, resp_valid SHALL be 1 and all resp_* outputs SHALL hold stable until resp_ready; on resp_valid & resp_ready the FSM SHALL return to IDLE.
REQ-018 Latency SHALL be: accept in cycle N, resp_valid first high in cycle N+2; minimum issue interval SHALL be 3 cycles.
REQ-019 Opcode decode SHALL be:
- 001 ADD
- 010 SUB (a-b)
- 011 AND
- 100 OR
- 101 NOR
- 110 SLT (unsigned a<b gives 1, else 0)
- 111 XNOR
REQ-020 Opcode 000 SHALL give resp_c=0 and resp_illegal=1; resp_illegal SHALL be 0 for all other opcodes.
REQ-021 resp_overflow SHALL be signed two's-complement overflow for ADD/SUB and 0 otherwise.
REQ-022 resp_carry SHALL be the carry out of bit DW-1 for ADD, the borrow (unsigned a<b) for SUB, and 0 otherwise.
REQ-023 resp_zero SHALL be 1 exactly when resp_c==0, including for an illegal opcode.
REQ-024 A requester deasserting valid before ready SHALL be legal; no transaction is recorded for it.
REQ-025 A request arriving while not in IDLE SHALL wait, unaccepted, until IDLE.
REQ-026 resp_ready asserted outside RESP SHALL be ignored.

Reset
REQ-027 While rst_n=0 the block SHALL be in IDLE with:
- resp_valid=0, resp_c=0, all flags 0, resp_id=0
- last_grant=1, so req0 wins the first contention
REQ-028 rst_n asserted in EXEC or RESP SHALL abort the operation; no response SHALL be produced for it.

Configuration
REQ-029 With ALU_ARB_RR_EN defined, when both requesters are valid in IDLE the block SHALL grant the one not granted last, and SHALL update last_grant on each accept.
REQ-030 Without ALU_ARB_RR_EN, req0 SHALL always win contention, and last_grant SHALL be omitted.

Structure
REQ-031 Package alu_ctrl_pkg SHALL hold the opcode localparams, the FSM state typedef and DW_DEFAULT.
REQ-032 Arbitration SHALL be in sub-module alu_rr_arb (inputs valid[1:0], enable, clk, rst_n; outputs grant[1:0]); the compute logic SHALL stay inline.

Verification
REQ-033 Reset then req0 ADD a=0x7FFFFFFF b=1 -> two cycles after accept, resp_c=0x80000000, overflow=1, carry=0, zero=0, id=0.
REQ-034 req1 SUB a=1 b=2 -> resp_c=0xFFFFFFFF, carry=1, overflow=0; ADD 0xFFFFFFFF+1 -> resp_c=0, carry=1, zero=1.
REQ-035 With RR enabled, both valid continuously for 4 transactions -> grants 0,1,0,1; with RR disabled -> 0,0,0,0.
REQ-036 resp_ready held 0 for 5 cycles in RESP -> resp_* stable, both readies 0, then one accept after release.
REQ-037 op=000 -> resp_c=0, illegal=1, zero=1; SLT a=3 b=0xFFFFFFFF -> resp_c=1.
REQ-038 rst_n pulsed low during EXEC -> resp_valid never rises for that request; the next request completes normally.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared opcodes, FSM state type and default datapath width for the arbitrated ALU.
package alu_ctrl_pkg;

    localparam int unsigned DW_DEFAULT = 32;

    localparam logic [2:0] OpIll = 3'b000;
    localparam logic [2:0] OpAdd = 3'b001;
    localparam logic [2:0] OpSub = 3'b010;
    localparam logic [2:0] OpAnd = 3'b011;
    localparam logic [2:0] OpOr  = 3'b100;
    localparam logic [2:0] OpNor = 3'b101;
    localparam logic [2:0] OpSlt = 3'b110;
    localparam logic [2:0] OpXnr = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_rr_arb.sv
// Two-way request arbiter. Define ALU_ARB_RR_EN for round-robin on contention;
// otherwise requester 0 has fixed priority.
module alu_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       enable,
    output logic [1:0] grant
);

`ifdef ALU_ARB_RR_EN
    // Index of the requester granted most recently; reset to 1 so requester 0 wins first.
    logic last_grant;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (valid == 2'b11) begin
                grant = last_grant ? 2'b01 : 2'b10;
            end else begin
                grant = valid;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (|grant) begin
            last_grant <= grant[1];
        end
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            grant = valid[0] ? 2'b01 : {valid[1], 1'b0};
        end
    end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU through an IDLE/EXEC/RESP handshake FSM.
// ALU_ARB_RR_EN selects round-robin arbitration in alu_rr_arb.
module alu_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    input  logic          req1_valid,
    output logic          req0_ready,
    output logic          req1_ready,
    input  logic [2:0]    req0_op,
    input  logic [2:0]    req1_op,
    input  logic [DW-1:0] req0_a,
    input  logic [DW-1:0] req0_b,
    input  logic [DW-1:0] req1_a,
    input  logic [DW-1:0] req1_b,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic          resp_id,
    output logic [DW-1:0] resp_c,
    output logic          resp_zero,
    output logic          resp_overflow,
    output logic          resp_carry,
    output logic          resp_illegal
);

    alu_state_e    state_q;
    logic [2:0]    op_q;
    logic [DW-1:0] a_q;
    logic [DW-1:0] b_q;
    logic          id_q;
    logic [1:0]    grant;

    alu_rr_arb u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid  ({req1_valid, req0_valid}),
        .enable (state_q == IDLE),
        .grant  (grant)
    );

    // Grant is only ever non-zero in IDLE, so it doubles as the ready handshake.
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    logic [DW:0]   add_full;
    logic [DW:0]   sub_full;
    logic [DW-1:0] alu_c;
    logic          alu_ovf;
    logic          alu_carry;
    logic          alu_ill;

    assign add_full = {1'b0, a_q} + {1'b0, b_q};
    // Top bit of the widened difference is the unsigned borrow (a < b).
    assign sub_full = {1'b0, a_q} - {1'b0, b_q};

    always_comb begin
        alu_c     = '0;
        alu_ovf   = 1'b0;
        alu_carry = 1'b0;
        alu_ill   = 1'b0;
        case (op_q)
            OpAdd: begin
                alu_c     = add_full[DW-1:0];
                alu_carry = add_full[DW];
                alu_ovf   = (a_q[DW-1] == b_q[DW-1]) && (add_full[DW-1] != a_q[DW-1]);
            end
            OpSub: begin
                alu_c     = sub_full[DW-1:0];
                alu_carry = sub_full[DW];
                alu_ovf   = (a_q[DW-1] != b_q[DW-1]) && (sub_full[DW-1] != a_q[DW-1]);
            end
            OpAnd: alu_c = a_q & b_q;
            OpOr:  alu_c = a_q | b_q;
            OpNor: alu_c = ~(a_q | b_q);
            OpSlt: alu_c = {{(DW-1){1'b0}}, sub_full[DW]};
            OpXnr: alu_c = ~(a_q ^ b_q);
            default: alu_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            op_q          <= OpIll;
            a_q           <= '0;
            b_q           <= '0;
            id_q          <= 1'b0;
            resp_valid    <= 1'b0;
            resp_id       <= 1'b0;
            resp_c        <= '0;
            resp_zero     <= 1'b0;
            resp_overflow <= 1'b0;
            resp_carry    <= 1'b0;
            resp_illegal  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (|grant) begin
                        op_q    <= grant[1] ? req1_op : req0_op;
                        a_q     <= grant[1] ? req1_a : req0_a;
                        b_q     <= grant[1] ? req1_b : req0_b;
                        id_q    <= grant[1];
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    resp_c        <= alu_c;
                    resp_zero     <= (alu_c == '0);
                    resp_overflow <= alu_ovf;
                    resp_carry    <= alu_carry;
                    resp_illegal  <= alu_ill;
                    resp_id       <= id_q;
                    resp_valid    <= 1'b1;
                    state_q       <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: driver pushes expected responses, monitor pops on handshake.
module tb_alu_arbiter;

    localparam int DW = 32;
`ifdef ALU_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    localparam logic [2:0] OP_ILL = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_NOR = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_XNR = 3'b111;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [2:0]    req0_op = '0, req1_op = '0;
    logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b1;
    logic          resp_id;
    logic [DW-1:0] resp_c;
    logic          resp_zero, resp_overflow, resp_carry, resp_illegal;

    alu_arbiter #(.DW(DW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req0_valid    (req0_valid),
        .req1_valid    (req1_valid),
        .req0_ready    (req0_ready),
        .req1_ready    (req1_ready),
        .req0_op       (req0_op),
        .req1_op       (req1_op),
        .req0_a        (req0_a),
        .req0_b        (req0_b),
        .req1_a        (req1_a),
        .req1_b        (req1_b),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_id       (resp_id),
        .resp_c        (resp_c),
        .resp_zero     (resp_zero),
        .resp_overflow (resp_overflow),
        .resp_carry    (resp_carry),
        .resp_illegal  (resp_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          id;
        logic [DW-1:0] c;
        logic          zero;
        logic          ovf;
        logic          carry;
        logic          ill;
    } resp_t;

    resp_t exp_q[$];
    resp_t mon_act, mon_exp;
    int    checks = 0;
    int    errors = 0;

    function automatic resp_t mk(input logic id, input logic [DW-1:0] c, input logic z,
                                 input logic v, input logic cy, input logic il);
        resp_t r;
        r.id = id; r.c = c; r.zero = z; r.ovf = v; r.carry = cy; r.ill = il;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h required %h", name, act, req);
        end
    endtask

    // Monitor: compare every completed response against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && resp_valid && resp_ready) begin
            mon_act = mk(resp_id, resp_c, resp_zero, resp_overflow, resp_carry, resp_illegal);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp got id=%0d c=%h required no response",
                         resp_id, resp_c);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    errors++;
                    $display("FAIL resp got id=%0d c=%h z%b v%b c%b i%b required id=%0d c=%h z%b v%b c%b i%b",
                             mon_act.id, mon_act.c, mon_act.zero, mon_act.ovf, mon_act.carry,
                             mon_act.ill, mon_exp.id, mon_exp.c, mon_exp.zero, mon_exp.ovf,
                             mon_exp.carry, mon_exp.ill);
                end
            end
        end
    end

    task automatic set_req(input logic id, input logic [2:0] op, input logic [DW-1:0] a,
                           input logic [DW-1:0] b);
        if (id) begin
            req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
        end else begin
            req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
        end
    endtask

    // Wait (bounded) for the given requester's ready at a falling edge.
    task automatic wait_ready(input logic id, output bit got);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = id ? req1_ready : req0_ready;
        end
        chk("accept", {63'd0, got}, 64'd1);
    endtask

    task automatic do_txn(input logic id, input logic [2:0] op, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input resp_t exp);
        bit got;
        set_req(id, op, a, b);
        wait_ready(id, got);
        if (got) exp_q.push_back(exp);
        @(posedge clk); #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
        if (got) begin
            @(negedge clk);
            chk("latency_n1", {63'd0, resp_valid}, 64'd0);
            @(negedge clk);
            chk("latency_n2", {63'd0, resp_valid}, 64'd1);
            @(posedge clk); #1;
        end
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_c", {32'd0, resp_c}, 64'd0);
        chk("rst_flags", {59'd0, resp_id, resp_zero, resp_overflow, resp_carry, resp_illegal},
            64'd0);
        chk("rst_ready", {62'd0, req1_ready, req0_ready}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          got;
        logic [1:0]  g;
        logic [1:0]  exp_g;
        int          n0;

        reset_dut();

        do_txn(1'b0, OP_ADD, 32'h7FFF_FFFF, 32'h1, mk(0, 32'h8000_0000, 0, 1, 0, 0));
        do_txn(1'b1, OP_SUB, 32'h1, 32'h2, mk(1, 32'hFFFF_FFFF, 0, 0, 1, 0));
        do_txn(1'b0, OP_ADD, 32'hFFFF_FFFF, 32'h1, mk(0, 32'h0, 1, 0, 1, 0));
        do_txn(1'b1, OP_ILL, 32'h5, 32'h6, mk(1, 32'h0, 1, 0, 0, 1));
        do_txn(1'b0, OP_SLT, 32'h3, 32'hFFFF_FFFF, mk(0, 32'h1, 0, 0, 0, 0));
        do_txn(1'b1, OP_SLT, 32'h5, 32'h3, mk(1, 32'h0, 1, 0, 0, 0));
        do_txn(1'b0, OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, mk(0, 32'h00F0_1234, 0, 0, 0, 0));
        do_txn(1'b1, OP_OR, 32'hF000_0000, 32'h0000_000F, mk(1, 32'hF000_000F, 0, 0, 0, 0));
        do_txn(1'b0, OP_NOR, 32'h0, 32'h0, mk(0, 32'hFFFF_FFFF, 0, 0, 0, 0));
        do_txn(1'b1, OP_NOR, 32'hFFFF_0000, 32'h0000_FFFF, mk(1, 32'h0, 1, 0, 0, 0));
        do_txn(1'b0, OP_XNR, 32'hAAAA_5555, 32'hAAAA_5555, mk(0, 32'hFFFF_FFFF, 0, 0, 0, 0));
        do_txn(1'b1, OP_XNR, 32'hA5A5_A5A5, 32'h5A5A_5A5A, mk(1, 32'h0, 1, 0, 0, 0));
        do_txn(1'b0, OP_SUB, 32'h8000_0000, 32'h1, mk(0, 32'h7FFF_FFFF, 0, 1, 0, 0));

        // Response stall: outputs hold, no request is accepted, a withdrawn request is dropped.
        resp_ready = 1'b0;
        set_req(1'b0, OP_OR, 32'hF000_0000, 32'h0000_000F);
        wait_ready(1'b0, got);
        if (got) exp_q.push_back(mk(0, 32'hF000_000F, 0, 0, 0, 0));
        @(posedge clk); #1;
        req0_valid = 1'b0;
        set_req(1'b1, OP_ADD, 32'd10, 32'd20);
        @(posedge clk); #1;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            chk("stall_hold", {26'd0, resp_valid, resp_id, resp_c, resp_zero, resp_overflow,
                               resp_carry, resp_illegal}, {26'd0, 1'b1, 1'b0, 32'hF000_000F, 4'b0});
            chk("stall_ready", {62'd0, req1_ready, req0_ready}, 64'd0);
            @(posedge clk); #1;
            if (s == 1) set_req(1'b0, OP_ADD, 32'h1, 32'h1);
            if (s == 2) req0_valid = 1'b0;
        end
        resp_ready = 1'b1;
        wait_ready(1'b1, got);
        if (got) exp_q.push_back(mk(1, 32'd30, 0, 0, 0, 0));
        @(posedge clk); #1;
        req1_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset during EXEC aborts the operation without a response.
        set_req(1'b0, OP_ADD, 32'h1, 32'h1);
        wait_ready(1'b0, got);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_rst_valid", {63'd0, resp_valid}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            chk("abort_no_resp", {63'd0, resp_valid}, 64'd0);
        end
        @(posedge clk); #1;
        do_txn(1'b0, OP_ADD, 32'h2, 32'h3, mk(0, 32'h5, 0, 0, 0, 0));

        // Continuous contention on both requesters.
        reset_dut();
        set_req(1'b0, OP_ADD, 32'h1000, 32'h0);
        set_req(1'b1, OP_SUB, 32'h2000, 32'h1);
        n0 = 0;
        for (int k = 0; k < 4; k++) begin
            exp_g = (RR && (k % 2 == 1)) ? 2'b10 : 2'b01;
            got = 1'b0;
            g = 2'b00;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                if (req0_ready || req1_ready) begin
                    got = 1'b1;
                    g = {req1_ready, req0_ready};
                end
            end
            chk("grant", {62'd0, g}, {62'd0, exp_g});
            if (exp_g[0]) begin
                exp_q.push_back(mk(0, 32'h1000 + n0, 0, 0, 0, 0));
                n0++;
            end else begin
                exp_q.push_back(mk(1, 32'h1FFF, 0, 0, 0, 0));
            end
            @(posedge clk); #1;
            if (g[0]) req0_b = req0_b + 1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
